// File: rtl/rv_pipe_pkg.sv
// Shared RV32I pipeline definitions: opcodes, the canonical NOP and the
// hazard sequencer state encoding.
package rv_pipe_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // add x0,x0,x0 -- what a flushed stage register holds
  localparam logic [31:0] NOP_INST = 32'h00000033;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline sequencing bus between the core stages (master) and hazard_ctrl
// (slave). Carries the decode/execute instructions, redirect request, memory
// handshakes, the stage strobes and the perf counters.
interface hazard_ctrl_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PERF_W = 32
);
  logic [31:0]       id_inst;
  logic [31:0]       ex_inst;
  logic              ex_redirect;
  logic [XLEN-1:0]   ex_redirect_tgt;
  logic              imem_ready;
  logic              dmem_busy;

  logic              pc_en;
  logic              ifid_en;
  logic              idex_en;
  logic              exmem_en;
  logic              memwb_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic              pc_redirect_valid;
  logic [XLEN-1:0]   pc_redirect_tgt;
  logic [PERF_W-1:0] lu_stall_cnt;
  logic [PERF_W-1:0] flush_cnt;
  logic [PERF_W-1:0] mem_wait_cnt;

  modport master (
    output id_inst, ex_inst, ex_redirect, ex_redirect_tgt, imem_ready, dmem_busy,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
    input  pc_redirect_valid, pc_redirect_tgt, lu_stall_cnt, flush_cnt, mem_wait_cnt
  );

  modport slave (
    input  id_inst, ex_inst, ex_redirect, ex_redirect_tgt, imem_ready, dmem_busy,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
    output pc_redirect_valid, pc_redirect_tgt, lu_stall_cnt, flush_cnt, mem_wait_cnt
  );

endinterface

// File: rtl/hazard_ctrl_src_use.sv
// rv_src_use: combinational RV32I field decode -- register specifiers, which
// source registers the opcode actually reads, and whether it is a load.
module rv_src_use
  import rv_pipe_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_rs1_used,
  output logic        o_rs2_used,
  output logic        o_is_load
);

  logic [6:0] w_op;
  logic       w_unused_bits;

  assign w_op  = i_inst[6:0];
  assign o_rs1 = i_inst[19:15];
  assign o_rs2 = i_inst[24:20];
  assign o_rd  = i_inst[11:7];

  // funct3/funct7 do not affect register usage
  assign w_unused_bits = ^{i_inst[31:25], i_inst[14:12]};

  // Opcode classes that read rs1/rs2; I-type immediates overlay rs2 and must not match
  always_comb begin
    o_rs1_used = w_op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JALR};
    o_rs2_used = w_op inside {OP_R, OP_STORE, OP_BR};
    o_is_load  = (w_op == OP_LOAD);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central 5-stage RV32I sequencing unit. Load-use bubbles,
// branch/jump redirect flushes and freezes on multicycle memory waits.
// Stage strobes are combinational from state and inputs (zero latency).
// Optional build macro: HAZARD_PERF_EN enables the perf counters; when it is
// undefined the counter outputs read zero and no counter state exists.
module hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned PERF_W          = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  if (LU_STALL_CYCLES < 1 || LU_STALL_CYCLES > 3) begin : g_bad_lu
    $error("hazard_ctrl: LU_STALL_CYCLES must be 1..3");
  end

  localparam logic [1:0] LU_INIT = 2'(LU_STALL_CYCLES - 1);

  hz_state_t       r_state;
  logic [1:0]      r_lu_cnt;
  logic            r_pend_valid;
  logic [XLEN-1:0] r_pend_tgt;

  hz_state_t       w_nxt_state;
  logic [1:0]      w_nxt_lu_cnt;
  logic            w_nxt_pend_valid;
  logic [XLEN-1:0] w_nxt_pend_tgt;

  logic            w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
  logic            w_ifid_flush, w_idex_flush;
  logic            w_redir_valid;
  logic [XLEN-1:0] w_redir_tgt;
  logic            w_lu_bubble, w_redir_cyc;

  logic [4:0]      w_id_rs1, w_id_rs2, w_id_rd, w_ex_rs1, w_ex_rs2, w_ex_rd;
  logic            w_id_rs1_used, w_id_rs2_used, w_id_is_load;
  logic            w_ex_rs1_used, w_ex_rs2_used, w_ex_is_load;
  logic            w_lu_hit;
  logic            w_unused_dec;

  rv_src_use u_id_dec (
    .i_inst     (bus.id_inst),
    .o_rs1      (w_id_rs1),
    .o_rs2      (w_id_rs2),
    .o_rd       (w_id_rd),
    .o_rs1_used (w_id_rs1_used),
    .o_rs2_used (w_id_rs2_used),
    .o_is_load  (w_id_is_load)
  );

  rv_src_use u_ex_dec (
    .i_inst     (bus.ex_inst),
    .o_rs1      (w_ex_rs1),
    .o_rs2      (w_ex_rs2),
    .o_rd       (w_ex_rd),
    .o_rs1_used (w_ex_rs1_used),
    .o_rs2_used (w_ex_rs2_used),
    .o_is_load  (w_ex_is_load)
  );

  assign w_unused_dec = ^{w_id_rd, w_id_is_load, w_ex_rs1, w_ex_rs2,
                          w_ex_rs1_used, w_ex_rs2_used};

  assign w_lu_hit = w_ex_is_load && (w_ex_rd != 5'd0) &&
                    ((w_id_rs1_used && (w_id_rs1 == w_ex_rd)) ||
                     (w_id_rs2_used && (w_id_rs2 == w_ex_rd)));

  // Priority: dmem_busy > redirect (live or pending) > load-use > fetch wait > run
  always_comb begin
    w_pc_en          = 1'b1;
    w_ifid_en        = 1'b1;
    w_idex_en        = 1'b1;
    w_exmem_en       = 1'b1;
    w_memwb_en       = 1'b1;
    w_ifid_flush     = 1'b0;
    w_idex_flush     = 1'b0;
    w_redir_valid    = 1'b0;
    w_redir_tgt      = '0;
    w_lu_bubble      = 1'b0;
    w_redir_cyc      = 1'b0;
    w_nxt_state      = r_state;
    w_nxt_lu_cnt     = r_lu_cnt;
    w_nxt_pend_valid = r_pend_valid;
    w_nxt_pend_tgt   = r_pend_tgt;

    if (bus.dmem_busy) begin
      {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = '0;
      w_nxt_state = MEM_WAIT;
      // Only the first redirect seen during a freeze is kept
      if (bus.ex_redirect && !r_pend_valid) begin
        w_nxt_pend_valid = 1'b1;
        w_nxt_pend_tgt   = bus.ex_redirect_tgt;
      end
    end else if (bus.ex_redirect || r_pend_valid) begin
      w_redir_valid    = 1'b1;
      w_redir_tgt      = r_pend_valid ? r_pend_tgt : bus.ex_redirect_tgt;
      w_ifid_flush     = 1'b1;
      w_idex_flush     = 1'b1;
      w_redir_cyc      = 1'b1;
      w_nxt_pend_valid = 1'b0;
      w_nxt_state      = RUN;
    end else if (r_state == LU_STALL) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
      w_lu_bubble  = 1'b1;
      w_nxt_lu_cnt = r_lu_cnt - 2'd1;
      if (r_lu_cnt == 2'd1) w_nxt_state = RUN;
    end else if (w_lu_hit) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
      w_lu_bubble  = 1'b1;
      w_nxt_lu_cnt = LU_INIT;
      w_nxt_state  = (LU_INIT != 2'd0) ? LU_STALL : RUN;
    end else if (!bus.imem_ready) begin
      w_pc_en      = 1'b0;
      w_ifid_flush = 1'b1;
      w_nxt_state  = RUN;
    end else begin
      w_nxt_state = RUN;
    end

    // Reset holds every stage frozen with NOPs injected, independent of the clock
    if (rst) begin
      {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = '0;
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_redir_valid = 1'b0;
      w_redir_tgt   = '0;
    end
  end

  // Sequencer state, bubble count and deferred redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RUN;
      r_lu_cnt     <= '0;
      r_pend_valid <= 1'b0;
      r_pend_tgt   <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_lu_cnt     <= w_nxt_lu_cnt;
      r_pend_valid <= w_nxt_pend_valid;
      r_pend_tgt   <= w_nxt_pend_tgt;
    end
  end

  assign bus.pc_en             = w_pc_en;
  assign bus.ifid_en           = w_ifid_en;
  assign bus.idex_en           = w_idex_en;
  assign bus.exmem_en          = w_exmem_en;
  assign bus.memwb_en          = w_memwb_en;
  assign bus.ifid_flush        = w_ifid_flush;
  assign bus.idex_flush        = w_idex_flush;
  assign bus.pc_redirect_valid = w_redir_valid;
  assign bus.pc_redirect_tgt   = w_redir_tgt;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] r_lu_stall_cnt, r_flush_cnt, r_mem_wait_cnt;

  // Free-running event counters, wrapping at 2^PERF_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lu_stall_cnt <= '0;
      r_flush_cnt    <= '0;
      r_mem_wait_cnt <= '0;
    end else begin
      if (w_lu_bubble)   r_lu_stall_cnt <= r_lu_stall_cnt + 1'b1;
      if (w_redir_cyc)   r_flush_cnt    <= r_flush_cnt + 1'b1;
      if (bus.dmem_busy) r_mem_wait_cnt <= r_mem_wait_cnt + 1'b1;
    end
  end

  assign bus.lu_stall_cnt = r_lu_stall_cnt;
  assign bus.flush_cnt    = r_flush_cnt;
  assign bus.mem_wait_cnt = r_mem_wait_cnt;
`else
  assign bus.lu_stall_cnt = {PERF_W{1'b0}};
  assign bus.flush_cnt    = {PERF_W{1'b0}};
  assign bus.mem_wait_cnt = {PERF_W{1'b0}};
`endif

endmodule
